// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared writeback types, widths and W-op sign extension
package wb_pkg;

    localparam int XLEN           = 64;
    localparam int REG_ADDR_WIDTH = 5;

    typedef struct packed {
        logic [XLEN-1:0] data;
        logic [4:0]      rd;
    } wb_entry_t;

    // RV64 W-ops produce a 32-bit result that is sign-extended into the full register
    function automatic logic [XLEN-1:0] sext_word(input logic [XLEN-1:0] r, input logic word_op);
        return word_op ? {{(XLEN-32){r[31]}}, r[31:0]} : r;
    endfunction

endpackage

// File: rtl/wb_scoreboard.sv
// rtl/wb_scoreboard.sv - destination-register pending bitmap with set/clear/query
module wb_scoreboard #(
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      set_en,
    input  logic [REG_ADDR_WIDTH-1:0] set_rd,
    input  logic                      clr_en,
    input  logic [REG_ADDR_WIDTH-1:0] clr_rd,
    input  logic [REG_ADDR_WIDTH-1:0] rs1_addr,
    input  logic [REG_ADDR_WIDTH-1:0] rs2_addr,
    output logic                      rs1_pending,
    output logic                      rs2_pending
);

    localparam int NREGS = 1 << REG_ADDR_WIDTH;

    logic [NREGS-1:0] pending_q, pending_d;

    // A new issue to the same rd outranks the retiring write, and survives a flush
    always_comb begin
        pending_d = pending_q;
        if (flush) begin
            pending_d = '0;
        end else if (clr_en) begin
            pending_d[clr_rd] = 1'b0;
        end
        if (set_en && set_rd != '0) begin
            pending_d[set_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign rs1_pending = (rs1_addr != '0) && pending_q[rs1_addr];
    assign rs2_pending = (rs2_addr != '0) && pending_q[rs2_addr];

endmodule

// File: rtl/alu_writeback.sv
// rtl/alu_writeback.sv - ALU writeback: result FIFO, register-file write port, scoreboard and forwarding
module alu_writeback #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int DEPTH          = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      issue_valid,
    input  logic [REG_ADDR_WIDTH-1:0] issue_rd,
    input  logic                      ex_valid,
    output logic                      ex_ready,
    input  logic [BUS_DATA_WIDTH-1:0] ex_result,
    input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
    input  logic                      ex_word_op,
    output logic                      rf_wr_en,
    output logic [REG_ADDR_WIDTH-1:0] rf_wr_addr,
    output logic [BUS_DATA_WIDTH-1:0] rf_wr_data,
    input  logic                      rf_wr_ready,
    input  logic [REG_ADDR_WIDTH-1:0] rs1_addr,
    input  logic [REG_ADDR_WIDTH-1:0] rs2_addr,
    output logic                      rs1_busy,
    output logic                      rs2_busy,
    output logic                      rs1_fwd_hit,
    output logic [BUS_DATA_WIDTH-1:0] rs1_fwd_data,
    output logic                      rs2_fwd_hit,
    output logic [BUS_DATA_WIDTH-1:0] rs2_fwd_data
);

    import wb_pkg::*;

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    wb_entry_t        fifo_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    wb_entry_t head;
    logic      head_valid;
    logic      head_wr;
    logic      enq;
    logic      deq;
    logic      rs1_pending;
    logic      rs2_pending;

    assign head       = fifo_q[rd_ptr_q];
    assign head_valid = (count_q != '0);
    assign head_wr    = head_valid && (head.rd != '0);

    // Ready comes from the registered count only, so a full buffer never passes through
    assign ex_ready = (count_q < CNT_W'(DEPTH));
    assign enq      = ex_valid && ex_ready && !flush;
    // rd==0 entries never write and retire on their first head cycle regardless of rf_wr_ready
    assign deq      = head_valid && ((head.rd == '0) || rf_wr_ready);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (enq) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (deq) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({enq, deq})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            fifo_q[wr_ptr_q] <= '{data: sext_word(ex_result, ex_word_op), rd: ex_rd};
        end
    end

    assign rf_wr_en   = head_wr;
    assign rf_wr_addr = head_wr ? head.rd : '0;
    assign rf_wr_data = head_wr ? head.data : '0;

    // Walk oldest to youngest so the last match (youngest) wins
    always_comb begin
        rs1_fwd_hit  = 1'b0;
        rs1_fwd_data = '0;
        rs2_fwd_hit  = 1'b0;
        rs2_fwd_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (CNT_W'(k) < count_q) begin
                if (rs1_addr != '0 && fifo_q[rd_ptr_q + PTR_W'(k)].rd == rs1_addr) begin
                    rs1_fwd_hit  = 1'b1;
                    rs1_fwd_data = fifo_q[rd_ptr_q + PTR_W'(k)].data;
                end
                if (rs2_addr != '0 && fifo_q[rd_ptr_q + PTR_W'(k)].rd == rs2_addr) begin
                    rs2_fwd_hit  = 1'b1;
                    rs2_fwd_data = fifo_q[rd_ptr_q + PTR_W'(k)].data;
                end
            end
        end
    end

    wb_scoreboard #(
        .REG_ADDR_WIDTH(REG_ADDR_WIDTH)
    ) u_scoreboard (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .set_en      (issue_valid),
        .set_rd      (issue_rd),
        .clr_en      (head_wr && rf_wr_ready),
        .clr_rd      (head.rd),
        .rs1_addr    (rs1_addr),
        .rs2_addr    (rs2_addr),
        .rs1_pending (rs1_pending),
        .rs2_pending (rs2_pending)
    );

    assign rs1_busy = rs1_pending && !rs1_fwd_hit;
    assign rs2_busy = rs2_pending && !rs2_fwd_hit;

endmodule
